fir_result_display: RTL and testbench



---
 rtl/fir_display_pkg.sv | 38 +++
 rtl/seg7_decoder.sv | 37 +++
 rtl/fir_result_display.sv | 123 ++++++++++++
 tb/tb_fir_result_display.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fir_display_pkg.sv
// ============================================================================
//  Module      : fir_display_pkg
//  Description : Shared types and constants for the FIR result display stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } disp_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int DEFAULT_MAX_VAL = 999;

    // Double-dabble correction; a legal nibble is <= 9 so the carry never exists
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
//  Module      : seg7_decoder
//  Description : BCD digit to active-low seven-segment map with blank input.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import fir_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_result_display.sv
// ============================================================================
//  Module      : fir_result_display
//  Description : Saturates a filtered sample to 0..MAX_VAL, converts it to BCD
//                by sequential double-dabble and drives three seven-segment
//                digits plus an overflow LED.
//                Optional macro FIR_DISPLAY_BLANK_LEADING_ZERO_EN blanks
//                leading zero digits on HEX2/HEX1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_result_display
    import fir_display_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic              LEDG
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0]        c_st_idle  = ST_IDLE;
    localparam logic [1:0]        c_st_shift = ST_SHIFT;
    localparam logic [1:0]        c_st_latch = ST_LATCH;
    localparam logic [DATA_W-1:0] c_max      = DATA_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  c_last     = CNT_W'(DATA_W - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_sat;
    logic [11:0]        r_bcd;
    logic               r_ovf;

    logic               w_ovf;
    logic [11:0]        w_adj;
    logic [DATA_W+11:0] w_shift;
    logic               w_blank1;
    logic               w_blank2;
    logic [6:0]         w_seg0;
    logic [6:0]         w_seg1;
    logic [6:0]         w_seg2;

    assign in_ready = (r_state == c_st_idle);
    assign busy     = (r_state != c_st_idle);
    assign w_ovf    = (in_data > c_max);

    assign w_adj   = {add3_if_ge5(r_bcd[11:8]),
                      add3_if_ge5(r_bcd[7:4]),
                      add3_if_ge5(r_bcd[3:0])};
    assign w_shift = {w_adj, r_sat} << 1;

`ifdef FIR_DISPLAY_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] c_hex_hi_rst = SEG_BLANK;
    assign w_blank2 = (r_bcd[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);
`else
    localparam logic [6:0] c_hex_hi_rst = SEG_0;
    assign w_blank2 = 1'b0;
    assign w_blank1 = 1'b0;
`endif

    seg7_decoder u_dec0 (.bcd(r_bcd[3:0]),  .blank(1'b0),     .seg(w_seg0));
    seg7_decoder u_dec1 (.bcd(r_bcd[7:4]),  .blank(w_blank1), .seg(w_seg1));
    seg7_decoder u_dec2 (.bcd(r_bcd[11:8]), .blank(w_blank2), .seg(w_seg2));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_sat   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            HEX0    <= SEG_0;
            HEX1    <= c_hex_hi_rst;
            HEX2    <= c_hex_hi_rst;
            LEDG    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_sat   <= w_ovf ? c_max : in_data;
                        r_ovf   <= w_ovf;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_bcd <= w_shift[DATA_W +: 12];
                    r_sat <= w_shift[DATA_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    // Display registers only move here, so no partial BCD is ever shown
                    HEX0    <= w_seg0;
                    HEX1    <= w_seg1;
                    HEX2    <= w_seg2;
                    LEDG    <= r_ovf;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_result_display.sv
// ============================================================================
//  Module      : tb_fir_result_display
//  Description : Directed self-checking bench for fir_result_display.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_result_display;

    localparam logic [6:0] E0 = 7'b1000000;
    localparam logic [6:0] E1 = 7'b1111001;
    localparam logic [6:0] E2 = 7'b0100100;
    localparam logic [6:0] E3 = 7'b0110000;
    localparam logic [6:0] E4 = 7'b0011001;
    localparam logic [6:0] E5 = 7'b0010010;
    localparam logic [6:0] E6 = 7'b0000010;
    localparam logic [6:0] E7 = 7'b1111000;
    localparam logic [6:0] E8 = 7'b0000000;
    localparam logic [6:0] E9 = 7'b0010000;
    localparam logic [6:0] EB = 7'b1111111;

`ifdef FIR_DISPLAY_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] HI_RST = EB;
    localparam logic [6:0] Z_HI   = EB;
`else
    localparam logic [6:0] HI_RST = E0;
    localparam logic [6:0] Z_HI   = E0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       busy;
    logic [6:0] HEX0, HEX1, HEX2;
    logic       LEDG;

    int total = 0;
    int bad   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    fir_result_display dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .LEDG     (LEDG)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends one sample, checks every busy cycle, optionally pulses a second
    // sample at edge k+3, and ends at the negedge after the LATCH edge k+11.
    task automatic run(input logic [9:0] val, input bit inj, input logic [9:0] inj_val);
        logic [20:0] prev;
        prev = {HEX2, HEX1, HEX0};
        @(negedge CLOCK_50);
        chk("ready_before", in_ready, 1'b1);
        in_data  = val;
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("busy_hi", busy, 1'b1);
            chk("ready_lo", in_ready, 1'b0);
            chk("hex_hold", {HEX2, HEX1, HEX0}, prev);
            if (inj && i == 2) begin
                in_data  = inj_val;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge CLOCK_50);
        end
        in_valid = 1'b0;
        chk("busy_done", busy, 1'b0);
        chk("ready_done", in_ready, 1'b1);
    endtask

    task automatic expect_disp(input string tag, input logic [6:0] h2, input logic [6:0] h1,
                               input logic [6:0] h0, input logic led);
        chk({tag, "_hex2"}, HEX2, h2);
        chk({tag, "_hex1"}, HEX1, h1);
        chk({tag, "_hex0"}, HEX0, h0);
        chk({tag, "_ledg"}, LEDG, led);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        expect_disp("rst", HI_RST, HI_RST, E0, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        run(10'd123, 1'b0, '0);
        expect_disp("d123", E1, E2, E3, 1'b0);

        run(10'd1023, 1'b0, '0);
        expect_disp("d1023", E9, E9, E9, 1'b1);

        run(10'd999, 1'b0, '0);
        expect_disp("d999", E9, E9, E9, 1'b0);

        run(10'd7, 1'b0, '0);
        expect_disp("d7", Z_HI, Z_HI, E7, 1'b0);

        run(10'd456, 1'b1, 10'd789);
        expect_disp("d456", E4, E5, E6, 1'b0);
        chk("no_restart_busy", busy, 1'b0);

        run(10'd789, 1'b0, '0);
        expect_disp("d789", E7, E8, E9, 1'b0);

        run(10'd1000, 1'b0, '0);
        expect_disp("d1000", E9, E9, E9, 1'b1);

        run(10'd60, 1'b0, '0);
        expect_disp("d60", Z_HI, E6, E0, 1'b0);

        // 555 accepted at edge k, reset asserted for edge k+5
        @(negedge CLOCK_50);
        in_data  = 10'd555;
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        chk("d555_busy", busy, 1'b1);
        repeat (4) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        expect_disp("midrst", HI_RST, HI_RST, E0, 1'b0);

        // reset and in_valid together: reset wins
        in_data  = 10'd321;
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rstvalid_ready", in_ready, 1'b1);
        chk("rstvalid_busy", busy, 1'b0);
        repeat (14) @(negedge CLOCK_50);
        expect_disp("after_rst", HI_RST, HI_RST, E0, 1'b0);

        run(10'd42, 1'b0, '0);
        expect_disp("d42", Z_HI, E4, E2, 1'b0);

        run(10'd0, 1'b0, '0);
        expect_disp("d0", Z_HI, Z_HI, E0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
